multicycle_control: RTL

//  Multi-cycle LEGv8 control unit; successor to the single-cycle decoder.

---
 rtl/multicycle_control_if.sv | 35 +++
 rtl/multicycle_control.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Bundle between the multi-cycle LEGv8 control unit and its memory/datapath side.
// master = control unit, slave = memory port plus datapath.
interface multicycle_control_if #(
  parameter int ALUOP_W = 2
);
  logic [31:0]        instr_in;
  logic               mem_ready;
  logic               zero;
  logic               ir_load;
  logic               mem_req;
  logic               mem_we;
  logic               IorD;
  logic               pc_write;
  logic [1:0]         pc_src;
  logic               Reg2Loc;
  logic               ALUSrc;
  logic [ALUOP_W-1:0] ALUOp;
  logic               MemtoReg;
  logic               RegWrite;
  logic               illegal;
  logic               timeout;
  logic [2:0]         state_o;

  modport master (
    input  instr_in, mem_ready, zero,
    output ir_load, mem_req, mem_we, IorD, pc_write, pc_src, Reg2Loc,
           ALUSrc, ALUOp, MemtoReg, RegWrite, illegal, timeout, state_o
  );

  modport slave (
    output instr_in, mem_ready, zero,
    input  ir_load, mem_req, mem_we, IorD, pc_write, pc_src, Reg2Loc,
           ALUSrc, ALUOp, MemtoReg, RegWrite, illegal, timeout, state_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control FSM over a shared memory port with bounded ready wait.
// Optional CBNZ decode is enabled by defining CTRL_CBNZ_EN.
module multicycle_control #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15,
  parameter int ALUOP_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX_R  = 3'd2,
    S_EX_D  = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5,
    S_EX_CB = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  localparam logic [10:0] R_OPS [4] = '{11'b10001011000, 11'b11001011000,
                                        11'b10001010000, 11'b10101010000};

  state_t              state_reg, state_next;
  logic [31:0]         ir_reg, ir_next;
  logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic                illegal_reg, illegal_next;
  logic                timeout_reg, timeout_next;

  logic [3:0] r_hit;
  logic       is_r, is_ldur, is_stur, is_cbz, is_cbnz, is_b, take_branch;
  logic       wait_expired;
  logic       unused_ir_bits;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rdec
      assign r_hit[gi] = (ir_reg[31:21] == R_OPS[gi]);
    end
  endgenerate

  assign is_r    = |r_hit;
  assign is_ldur = (ir_reg[31:21] == 11'b11111000010);
  assign is_stur = (ir_reg[31:21] == 11'b11111000000);
  assign is_cbz  = (ir_reg[31:24] == 8'b10110100);
  assign is_b    = (ir_reg[31:26] == 6'b000101);
`ifdef CTRL_CBNZ_EN
  assign is_cbnz = (ir_reg[31:24] == 8'b10110101);
`else
  assign is_cbnz = 1'b0;
`endif
  assign take_branch    = (is_cbz & bus.zero) | (is_cbnz & ~bus.zero);
  assign wait_expired   = (wait_cnt_reg == WAIT_W'(MAX_WAIT - 1));
  assign unused_ir_bits = ^ir_reg[20:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IF;
      ir_reg       <= '0;
      wait_cnt_reg <= '0;
      illegal_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ir_reg       <= ir_next;
      wait_cnt_reg <= wait_cnt_next;
      illegal_reg  <= illegal_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ir_next       = ir_reg;
    wait_cnt_next = wait_cnt_reg;
    illegal_next  = illegal_reg;
    timeout_next  = timeout_reg;
    case (state_reg)
      S_IF: begin
        if (bus.mem_ready) begin
          ir_next    = bus.instr_in;
          state_next = S_ID;
        end else if (wait_expired) begin
          timeout_next = 1'b1;
          state_next   = S_ERR;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      S_ID: begin
        if (is_r)                   state_next = S_EX_R;
        else if (is_ldur | is_stur) state_next = S_EX_D;
        else if (is_cbz | is_cbnz)  state_next = S_EX_CB;
        else if (is_b)              state_next = S_IF;
        else begin
          illegal_next = 1'b1;
          state_next   = S_ERR;
        end
      end
      S_EX_R:  state_next = S_WB;
      S_EX_D:  state_next = S_MEM;
      S_MEM: begin
        if (bus.mem_ready) begin
          state_next = is_stur ? S_IF : S_WB;
        end else if (wait_expired) begin
          timeout_next = 1'b1;
          state_next   = S_ERR;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      S_WB:    state_next = S_IF;
      S_EX_CB: state_next = S_IF;
      default: state_next = S_ERR;
    endcase
    if (state_next != state_reg) wait_cnt_next = '0;
  end

  // Strobes are forced low while rst is high so a reset mid-request aborts it at once.
  always_comb begin
    bus.ir_load  = 1'b0;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.IorD     = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_src   = 2'b00;
    bus.Reg2Loc  = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.ALUOp    = '0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    if (!rst) begin
      case (state_reg)
        S_IF: begin
          bus.mem_req  = 1'b1;
          bus.ir_load  = bus.mem_ready;
          bus.pc_write = bus.mem_ready;
        end
        S_ID: begin
          bus.Reg2Loc = is_stur;
          if (is_b) begin
            bus.pc_write = 1'b1;
            bus.pc_src   = 2'b10;
          end
        end
        S_EX_R: bus.ALUOp = ALUOP_W'(2'b10);
        S_EX_D: begin
          bus.ALUSrc  = 1'b1;
          bus.Reg2Loc = is_stur;
        end
        S_MEM: begin
          bus.mem_req = 1'b1;
          bus.IorD    = 1'b1;
          bus.mem_we  = is_stur;
          bus.ALUSrc  = 1'b1;
        end
        S_WB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = is_ldur;
        end
        S_EX_CB: begin
          bus.Reg2Loc  = 1'b1;
          bus.ALUOp    = ALUOP_W'(2'b01);
          bus.pc_write = take_branch;
          bus.pc_src   = take_branch ? 2'b01 : 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign bus.illegal = illegal_reg;
  assign bus.timeout = timeout_reg;
  assign bus.state_o = state_reg;

endmodule
